// File: rtl/bus_pkg.sv
// bus_pkg: shared system-bus defaults and split-slave FSM state encoding
package bus_pkg;
  localparam int ADDR_WIDTH_DEF = 12;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int SPLIT_THRESH_DEF = 4;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ACCESS     = 2'd1,
    SPLIT      = 2'd2,
    WAIT_GRANT = 2'd3
  } state_e;
endpackage

// File: rtl/split_slave_ctrl.sv
// split_slave_ctrl: split-capable slave controller bridging the bus to a slow req/ack memory
//   bus side   : mvalid/mwrite/maddr/mwdata in, sreadysp/ssplit/srvalid/srdata out, split_grant in
//   memory side: mem_req/mem_we/mem_addr/mem_wdata out, mem_ack/mem_rdata in
//   clk, rstn (synchronous, active-low)
module split_slave_ctrl
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int SPLIT_THRESH = SPLIT_THRESH_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  mvalid,
  input  logic                  mwrite,
  input  logic [ADDR_WIDTH-1:0] maddr,
  input  logic [DATA_WIDTH-1:0] mwdata,
  output logic                  sreadysp,
  output logic                  ssplit,
  input  logic                  split_grant,
  output logic                  srvalid,
  output logic [DATA_WIDTH-1:0] srdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam int CW = $clog2(SPLIT_THRESH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SPLIT_THRESH - 1);
  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  ssplit_q, ssplit_d;
  logic                  srvalid_q, srvalid_d;
  logic [DATA_WIDTH-1:0] srdata_q, srdata_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      ssplit_q    <= 1'b0;
      srvalid_q   <= 1'b0;
      srdata_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      ssplit_q    <= ssplit_d;
      srvalid_q   <= srvalid_d;
      srdata_q    <= srdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // srvalid defaults low so every completion is a single-cycle strobe
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    ssplit_d    = ssplit_q;
    srvalid_d   = 1'b0;
    srdata_d    = srdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: if (mvalid) begin
        mem_req_d   = 1'b1;
        mem_we_d    = mwrite;
        mem_addr_d  = maddr;
        mem_wdata_d = mwdata;
        cnt_d       = '0;
        state_d     = ACCESS;
      end
      // an ack on the threshold cycle takes priority over declaring a split
      ACCESS: if (mem_ack) begin
        mem_req_d = 1'b0;
        srvalid_d = 1'b1;
        srdata_d  = mem_we_q ? srdata_q : mem_rdata;
        state_d   = IDLE;
      end else if (cnt_q == CNT_LAST) begin
        ssplit_d = 1'b1;
        state_d  = SPLIT;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      // read data is parked until the arbiter hands the bus back to the owner
      SPLIT: if (mem_ack) begin
        mem_req_d = 1'b0;
        hold_d    = mem_we_q ? hold_q : mem_rdata;
        ssplit_d  = 1'b0;
        state_d   = WAIT_GRANT;
      end
      WAIT_GRANT: if (split_grant) begin
        srdata_d  = mem_we_q ? srdata_q : hold_q;
        srvalid_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sreadysp  = (state_q == IDLE);
  assign ssplit    = ssplit_q;
  assign srvalid   = srvalid_q;
  assign srdata    = srdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_split_slave_ctrl.sv
// tb_split_slave_ctrl: scoreboard bench for split_slave_ctrl
module tb_split_slave_ctrl;
  localparam int TH = 4;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mvalid = 1'b0, mwrite = 1'b0;
  logic [11:0] maddr = '0;
  logic [7:0]  mwdata = '0;
  logic        sreadysp, ssplit, split_grant = 1'b0, srvalid;
  logic [7:0]  srdata;
  logic        mem_req, mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  int          n_checks = 0, n_errors = 0, n_pulses = 0, n_expected = 0;
  logic [7:0]  sb[$];
  logic [7:0]  exp_srdata = '0;
  logic        prev_srvalid = 1'b0;

  split_slave_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .SPLIT_THRESH(TH)) dut (
    .clk(clk), .rstn(rstn), .mvalid(mvalid), .mwrite(mwrite), .maddr(maddr), .mwdata(mwdata),
    .sreadysp(sreadysp), .ssplit(ssplit), .split_grant(split_grant), .srvalid(srvalid),
    .srdata(srdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (srvalid) begin
      n_pulses++;
      check("srvalid_back_to_back", {31'd0, prev_srvalid}, 32'd0);
      if (sb.size() == 0) check("sb_unexpected_srvalid", 32'd1, 32'd0);
      else check("sb_srdata", {24'd0, srdata}, {24'd0, sb.pop_front()});
    end
    prev_srvalid = srvalid;
  end

  // d: cycles from mem_req rising to mem_ack; g: idle cycles before split_grant
  task automatic txn(input logic wr, input logic [11:0] a, input logic [7:0] wd, input int d,
                     input logic [7:0] rd, input int g, input bit intf);
    check("idle_ready", {31'd0, sreadysp}, 32'd1);
    mvalid = 1'b1; mwrite = wr; maddr = a; mwdata = wd;
    exp_srdata = wr ? exp_srdata : rd;
    sb.push_back(exp_srdata);
    n_expected++;
    step();
    mvalid = 1'b0;
    check("req_we", {31'd0, mem_we}, {31'd0, wr});
    if (wr) check("req_wdata", {24'd0, mem_wdata}, {24'd0, wd});
    for (int c = 1; c <= d + 1; c++) begin
      check("wait_ssplit", {31'd0, ssplit}, {31'd0, (c - 1) >= TH});
      check("wait_busy", {31'd0, sreadysp}, 32'd0);
      check("wait_srvalid", {31'd0, srvalid}, 32'd0);
      check("wait_mem_req", {31'd0, mem_req}, 32'd1);
      check("wait_mem_addr", {20'd0, mem_addr}, {20'd0, a});
      mvalid = intf && c == TH + 2;
      maddr = (intf && c == TH + 2) ? ~a : a;
      split_grant = intf && c == TH + 2;
      mem_ack = (c == d + 1);
      mem_rdata = mem_ack ? rd : 8'($urandom);
      step();
    end
    mem_ack = 1'b0; mvalid = 1'b0; split_grant = 1'b0;
    if (d >= TH) begin
      check("ack_ssplit_drop", {31'd0, ssplit}, 32'd0);
      check("ack_mem_req_drop", {31'd0, mem_req}, 32'd0);
      check("ack_no_srvalid", {31'd0, srvalid}, 32'd0);
      repeat (g) begin
        step();
        check("grant_wait_srvalid", {31'd0, srvalid}, 32'd0);
        check("grant_wait_busy", {31'd0, sreadysp}, 32'd0);
      end
      split_grant = 1'b1;
      step();
      split_grant = 1'b0;
    end
    check("done_srvalid", {31'd0, srvalid}, 32'd1);
    check("done_srdata", {24'd0, srdata}, {24'd0, exp_srdata});
    check("done_mem_req", {31'd0, mem_req}, 32'd0);
    check("done_ssplit", {31'd0, ssplit}, 32'd0);
    step();
    check("after_srvalid_low", {31'd0, srvalid}, 32'd0);
    check("after_ready", {31'd0, sreadysp}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    step();
    step();
    rstn = 1'b1;
    check("rst_ssplit", {31'd0, ssplit}, 32'd0);
    check("rst_srvalid", {31'd0, srvalid}, 32'd0);
    check("rst_srdata", {24'd0, srdata}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check("rst_sreadysp", {31'd0, sreadysp}, 32'd1);
    step();
    txn(1'b0, 12'h01A, 8'h00, 2, 8'h5C, 0, 1'b0);
    txn(1'b0, 12'h055, 8'h00, 10, 8'hA7, 3, 1'b0);
    txn(1'b0, 12'h0F0, 8'h00, TH - 1, 8'h6E, 0, 1'b0);
    txn(1'b1, 12'h100, 8'h33, 1, 8'hF1, 0, 1'b0);
    txn(1'b0, 12'h0C3, 8'h00, TH, 8'h4D, 0, 1'b0);
    txn(1'b1, 12'h101, 8'h44, TH + 1, 8'hE2, 2, 1'b0);
    txn(1'b0, 12'h2AB, 8'h00, 8, 8'h91, 1, 1'b1);
    mvalid = 1'b1; mwrite = 1'b0; maddr = 12'h3C0;
    step();
    mvalid = 1'b0;
    repeat (TH + 1) step();
    check("pre_rst_ssplit", {31'd0, ssplit}, 32'd1);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    exp_srdata = 8'h00;
    check("midrst_ssplit", {31'd0, ssplit}, 32'd0);
    check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst_srvalid", {31'd0, srvalid}, 32'd0);
    check("midrst_sreadysp", {31'd0, sreadysp}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 8'hBB;
    step();
    mem_ack = 1'b0;
    check("stray_ack_srvalid", {31'd0, srvalid}, 32'd0);
    check("stray_ack_ready", {31'd0, sreadysp}, 32'd1);
    step();
    check("stray_ack_srvalid2", {31'd0, srvalid}, 32'd0);
    txn(1'b0, 12'h011, 8'h00, 0, 8'h11, 0, 1'b0);
    txn(1'b0, 12'h022, 8'h00, 1, 8'h22, 0, 1'b0);
    repeat (3) step();
    check("sb_empty", sb.size(), 32'd0);
    check("pulse_count", n_pulses, n_expected);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/split_slave_ctrl.md
Name: split_slave_ctrl

Overview:
- Slave-side controller for the split-capable slave on the two-master system bus. Sits directly downstream of the bus arbiter.
- Accepts a decoded read/write transaction and forwards it to a slow memory through a req/ack handshake.
- If the memory does not answer within SPLIT_THRESH cycles, it raises ssplit so the arbiter can park the owning master and let the other master use the non-split slaves.
- When memory data arrives it drops ssplit, waits for the arbiter's split_grant pulse, then returns the response.

Parameters:
- ADDR_WIDTH, 12, slave-local address width.
- DATA_WIDTH, 8, data width.
- SPLIT_THRESH, 4, ACCESS-state cycles without mem_ack before a split is declared; legal range ≥1.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- mvalid  in  1  transaction request from the granted master, already decoded to this slave.
- mwrite  in  1  1=write, 0=read; sampled with mvalid.
- maddr  in  ADDR_WIDTH  address; sampled with mvalid.
- mwdata  in  DATA_WIDTH  write data; sampled with mvalid.
- sreadysp  out  1  slave ready, to the arbiter.
- ssplit  out  1  split active, to the arbiter.
- split_grant  in  1  one-cycle pulse from the arbiter: the split owner is back on the bus.
- srvalid  out  1  one-cycle response/completion strobe (reads and writes).
- srdata  out  DATA_WIDTH  read data; valid when srvalid=1.
- mem_req  out  1  memory request, level.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_ack  in  1  memory completion, one-cycle pulse.
- mem_rdata  in  DATA_WIDTH  read data; valid with mem_ack.

Behaviour:
- Output sourcing:
  - ssplit, srvalid, srdata, mem_req, mem_we, mem_addr, mem_wdata are registered.
  - sreadysp = (state==IDLE), combinational.
- Reset (rstn=0 at a clk edge):
  - state=IDLE; ssplit=0, srvalid=0, srdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cnt=0.
  - sreadysp=1 after reset.
  - Reset mid-transaction (any state) aborts it. No response is issued. mem_req drops the next cycle.
- States: IDLE, ACCESS, SPLIT, WAIT_GRANT.
- IDLE:
  - On mvalid=1: latch mwrite/maddr/mwdata onto mem_we/mem_addr/mem_wdata; mem_req<=1; cnt<=0; go to ACCESS.
  - mvalid in any other state is ignored, and sreadysp=0 signals busy.
- ACCESS:
  - If mem_ack=1: mem_req<=0; srdata<=mem_rdata if read, else srdata unchanged; srvalid<=1 for one cycle; go to IDLE. No split occurs.
  - Else if cnt==SPLIT_THRESH-1: ssplit<=1; go to SPLIT.
  - Else cnt<=cnt+1.
  - mem_ack in the same cycle as the threshold is reached: ack wins, no split.
  - cnt width is $clog2(SPLIT_THRESH+1) and it never wraps.
- SPLIT:
  - mem_req stays held; mem_addr/mem_we/mem_wdata are stable.
  - On mem_ack: mem_req<=0; capture mem_rdata into an internal hold register (reads); ssplit<=0; go to WAIT_GRANT.
- WAIT_GRANT:
  - ssplit=0 lets the arbiter return the bus to the split owner.
  - On split_grant=1: srdata<=held data (reads); srvalid<=1 for one cycle; go to IDLE.
  - No timeout: the arbiter always grants the split owner once ssplit is low.
- split_grant outside WAIT_GRANT is ignored. mem_ack outside ACCESS/SPLIT is ignored.
- Exactly one srvalid pulse per accepted transaction (reset excepted). srvalid is never high two consecutive cycles.
- Minimum latency, no split: mvalid at cycle 0, mem_req at cycle 1, earliest mem_ack at cycle 1, srvalid at cycle 2.
- Split latency: ssplit rises SPLIT_THRESH cycles after mem_req rises, provided no ack arrives in that window.

Decomposition:
- Shared package bus_pkg:
  - State encoding localparams (IDLE/ACCESS/SPLIT/WAIT_GRANT).
  - SPLIT_THRESH default.
  - Common ADDR_WIDTH/DATA_WIDTH defaults shared with the arbiter and master ports.
- Sub-module: none needed. Single-file FSM with counter and hold register.

Test Plan:
1. Fast read (SPLIT_THRESH=4): mvalid read at maddr=0x01A; mem_ack with mem_rdata=0x5C two cycles after mem_req -> ssplit never high; srvalid=1, srdata=0x5C exactly one cycle later; sreadysp=1 again.
2. Slow read: mem_ack after 10 cycles with mem_rdata=0xA7 -> ssplit=1 from the 5th cycle after mem_req until the cycle after mem_ack; sreadysp=0 throughout. Then split_grant pulse 3 cycles later -> srvalid=1, srdata=0xA7 the next cycle.
3. Boundary: mem_ack arrives exactly on ACCESS cycle cnt==3 (SPLIT_THRESH=4) -> no ssplit; srvalid next cycle. Write mwdata=0x33 at 0x100 -> mem_we=1, mem_wdata=0x33, srvalid pulse, srdata unchanged.
4. Interference: during SPLIT, drive mvalid with a new address and an early split_grant -> both ignored; mem_addr unchanged; no srvalid until the post-ack split_grant.
5. Reset mid-split: rstn=0 for one cycle while in SPLIT -> next cycle ssplit=0, mem_req=0, srvalid=0, sreadysp=1. A later stray mem_ack produces no srvalid.
6. Back-to-back: two read transactions, the second mvalid the cycle after the first srvalid -> both complete in order with correct data. Exactly two srvalid pulses.
